// File: rtl/rx_sync_ctrl_pkg.sv
// Shared 8b/10b code-group constants and sync FSM state encodings for the receive sync block.
package rx_sync_ctrl_pkg;

  localparam logic [3:0] ST_LOSS_OF_SYNC     = 4'd0;
  localparam logic [3:0] ST_COMMA_DETECT_1   = 4'd1;
  localparam logic [3:0] ST_ACQUIRE_SYNC_1   = 4'd2;
  localparam logic [3:0] ST_COMMA_DETECT_2   = 4'd3;
  localparam logic [3:0] ST_ACQUIRE_SYNC_2   = 4'd4;
  localparam logic [3:0] ST_COMMA_DETECT_3   = 4'd5;
  localparam logic [3:0] ST_SYNC_ACQUIRED_1  = 4'd6;
  localparam logic [3:0] ST_SYNC_ACQUIRED_2  = 4'd7;
  localparam logic [3:0] ST_SYNC_ACQUIRED_2A = 4'd8;
  localparam logic [3:0] ST_SYNC_ACQUIRED_3  = 4'd9;
  localparam logic [3:0] ST_SYNC_ACQUIRED_3A = 4'd10;
  localparam logic [3:0] ST_SYNC_ACQUIRED_4  = 4'd11;
  localparam logic [3:0] ST_SYNC_ACQUIRED_4A = 4'd12;

  // Code-groups are abcdei_fghj with 'a' in bit 9.
  localparam logic [9:0] K28_5_NEG = 10'h0FA;
  localparam logic [9:0] K28_5_POS = 10'h305;

  // Control code-groups accepted as valid: K28.5, K23.7, K27.7, K29.7 in both disparities.
  localparam int K_NUM = 8;
  localparam logic [9:0] K_LIST [K_NUM] = '{
    10'h0FA, 10'h305, 10'h3A8, 10'h057, 10'h368, 10'h097, 10'h2E8, 10'h117
  };

  // 6b sub-block lookup: legal as RD- form, legal as RD+ form, and its 5b value.
  typedef struct packed {
    logic       in_n;
    logic       in_p;
    logic [4:0] x;
  } d6_t;

  localparam logic [1:0] D6_N = 2'b10;
  localparam logic [1:0] D6_P = 2'b01;
  localparam logic [1:0] D6_B = 2'b11;

  function automatic d6_t d6_lookup(input logic [5:0] s6);
    d6_t r;
    r = '0;
    case (s6)
      6'b100111: r = {D6_N, 5'd0};   6'b011000: r = {D6_P, 5'd0};
      6'b011101: r = {D6_N, 5'd1};   6'b100010: r = {D6_P, 5'd1};
      6'b101101: r = {D6_N, 5'd2};   6'b010010: r = {D6_P, 5'd2};
      6'b110001: r = {D6_B, 5'd3};
      6'b110101: r = {D6_N, 5'd4};   6'b001010: r = {D6_P, 5'd4};
      6'b101001: r = {D6_B, 5'd5};
      6'b011001: r = {D6_B, 5'd6};
      6'b111000: r = {D6_N, 5'd7};   6'b000111: r = {D6_P, 5'd7};
      6'b111001: r = {D6_N, 5'd8};   6'b000110: r = {D6_P, 5'd8};
      6'b100101: r = {D6_B, 5'd9};
      6'b010101: r = {D6_B, 5'd10};
      6'b110100: r = {D6_B, 5'd11};
      6'b001101: r = {D6_B, 5'd12};
      6'b101100: r = {D6_B, 5'd13};
      6'b011100: r = {D6_B, 5'd14};
      6'b010111: r = {D6_N, 5'd15};  6'b101000: r = {D6_P, 5'd15};
      6'b011011: r = {D6_N, 5'd16};  6'b100100: r = {D6_P, 5'd16};
      6'b100011: r = {D6_B, 5'd17};
      6'b010011: r = {D6_B, 5'd18};
      6'b110010: r = {D6_B, 5'd19};
      6'b001011: r = {D6_B, 5'd20};
      6'b101010: r = {D6_B, 5'd21};
      6'b011010: r = {D6_B, 5'd22};
      6'b111010: r = {D6_N, 5'd23};  6'b000101: r = {D6_P, 5'd23};
      6'b110011: r = {D6_N, 5'd24};  6'b001100: r = {D6_P, 5'd24};
      6'b100110: r = {D6_B, 5'd25};
      6'b010110: r = {D6_B, 5'd26};
      6'b110110: r = {D6_N, 5'd27};  6'b001001: r = {D6_P, 5'd27};
      6'b001110: r = {D6_B, 5'd28};
      6'b101110: r = {D6_N, 5'd29};  6'b010001: r = {D6_P, 5'd29};
      6'b011110: r = {D6_N, 5'd30};  6'b100001: r = {D6_P, 5'd30};
      6'b101011: r = {D6_N, 5'd31};  6'b010100: r = {D6_P, 5'd31};
      default:   r = '0;
    endcase
    return r;
  endfunction

  function automatic logic is_sync_acquired(input logic [3:0] st);
    return st inside {ST_SYNC_ACQUIRED_1, ST_SYNC_ACQUIRED_2, ST_SYNC_ACQUIRED_2A,
                      ST_SYNC_ACQUIRED_3, ST_SYNC_ACQUIRED_3A, ST_SYNC_ACQUIRED_4,
                      ST_SYNC_ACQUIRED_4A};
  endfunction

endpackage

// File: rtl/rx_sync_ctrl_cg_classify.sv
// Combinational code-group classifier: comma, data and cgbad from SUDI and the current EVEN.
// Zero latency, no flow control.
module cg_classify
  import rx_sync_ctrl_pkg::*;
(
  input  logic [9:0] sudi,
  input  logic       even,
  output logic       comma,
  output logic       data,
  output logic       cgbad
);

  d6_t        s6;
  logic [3:0] f4;
  logic [2:0] ones6;
  logic       mid_neg, mid_pos, a7_neg, a7_pos, ok4_neg, ok4_pos, kcode;

  always_comb begin
    s6    = d6_lookup(sudi[9:4]);
    f4    = sudi[3:0];
    ones6 = 3'($countones(sudi[9:4]));
    // Running disparity between the sub-blocks, for each legal starting disparity.
    mid_neg = (s6.in_n && ones6 == 3'd3) || (s6.in_p && ones6 == 3'd2);
    mid_pos = (s6.in_n && ones6 == 3'd4) || (s6.in_p && ones6 == 3'd3);
    a7_neg  = s6.x inside {5'd17, 5'd18, 5'd20};
    a7_pos  = s6.x inside {5'd11, 5'd13, 5'd14};

    ok4_neg = 1'b0;
    case (f4)
      4'b1011, 4'b1001, 4'b0101, 4'b1100,
      4'b1101, 4'b1010, 4'b0110: ok4_neg = 1'b1;
      4'b1110:                   ok4_neg = !a7_neg;
      4'b0111:                   ok4_neg = a7_neg;
      default:                   ok4_neg = 1'b0;
    endcase

    ok4_pos = 1'b0;
    case (f4)
      4'b0100, 4'b1001, 4'b0101, 4'b0011,
      4'b0010, 4'b1010, 4'b0110: ok4_pos = 1'b1;
      4'b0001:                   ok4_pos = !a7_pos;
      4'b1000:                   ok4_pos = a7_pos;
      default:                   ok4_pos = 1'b0;
    endcase

    kcode = 1'b0;
    for (int i = 0; i < K_NUM; i++) begin
      if (sudi == K_LIST[i]) kcode = 1'b1;
    end

    data  = (mid_neg && ok4_neg) || (mid_pos && ok4_pos);
    comma = (sudi == K28_5_NEG) || (sudi == K28_5_POS);
    cgbad = !(data || kcode) || (comma && even);
  end

endmodule

// File: rtl/rx_sync_ctrl.sv
// Receive code-group synchronisation FSM: acquires comma alignment, tracks EVEN and sync_status.
// One cycle SUDI to SUDI_q/EVEN/sync_status; no backpressure, one code-group per clk.
module rx_sync_ctrl
  import rx_sync_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       mr_main_reset,
  input  logic [9:0] SUDI,
  input  logic       signal_detect,
  output logic [9:0] SUDI_q,
  output logic       EVEN,
  output logic       sync_status,
  output logic [3:0] sync_state
);

  logic [3:0] state, state_nxt, up_st, alt_st, dn_st;
  logic [1:0] good_cnt, good_cnt_nxt;
  logic       comma, data, cgbad, even_nxt;

  cg_classify u_classify (
    .sudi  (SUDI),
    .even  (EVEN),
    .comma (comma),
    .data  (data),
    .cgbad (cgbad)
  );

  always_comb begin
    up_st  = ST_SYNC_ACQUIRED_1;
    alt_st = ST_SYNC_ACQUIRED_2A;
    dn_st  = ST_SYNC_ACQUIRED_3;
    case (state)
      ST_SYNC_ACQUIRED_3, ST_SYNC_ACQUIRED_3A: begin
        up_st = ST_SYNC_ACQUIRED_2; alt_st = ST_SYNC_ACQUIRED_3A; dn_st = ST_SYNC_ACQUIRED_4;
      end
      ST_SYNC_ACQUIRED_4, ST_SYNC_ACQUIRED_4A: begin
        up_st = ST_SYNC_ACQUIRED_3; alt_st = ST_SYNC_ACQUIRED_4A; dn_st = ST_LOSS_OF_SYNC;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    good_cnt_nxt = good_cnt;
    case (state)
      ST_LOSS_OF_SYNC:   if (comma) state_nxt = ST_COMMA_DETECT_1;
      ST_COMMA_DETECT_1: state_nxt = data ? ST_ACQUIRE_SYNC_1 : ST_LOSS_OF_SYNC;
      ST_COMMA_DETECT_2: state_nxt = data ? ST_ACQUIRE_SYNC_2 : ST_LOSS_OF_SYNC;
      ST_COMMA_DETECT_3: state_nxt = data ? ST_SYNC_ACQUIRED_1 : ST_LOSS_OF_SYNC;
      ST_ACQUIRE_SYNC_1: begin
        if (cgbad) state_nxt = ST_LOSS_OF_SYNC;
        else if (comma && !EVEN) state_nxt = ST_COMMA_DETECT_2;
      end
      ST_ACQUIRE_SYNC_2: begin
        if (cgbad) state_nxt = ST_LOSS_OF_SYNC;
        else if (comma && !EVEN) state_nxt = ST_COMMA_DETECT_3;
      end
      ST_SYNC_ACQUIRED_1: begin
        if (cgbad) begin
          state_nxt    = ST_SYNC_ACQUIRED_2;
          good_cnt_nxt = '0;
        end
      end
      ST_SYNC_ACQUIRED_2, ST_SYNC_ACQUIRED_2A, ST_SYNC_ACQUIRED_3,
      ST_SYNC_ACQUIRED_3A, ST_SYNC_ACQUIRED_4, ST_SYNC_ACQUIRED_4A: begin
        if (cgbad) begin
          state_nxt    = dn_st;
          good_cnt_nxt = '0;
        end else if (good_cnt == 2'd3) begin
          state_nxt    = up_st;
          good_cnt_nxt = '0;
        end else begin
          state_nxt    = alt_st;
          good_cnt_nxt = good_cnt + 2'd1;
        end
      end
      default: state_nxt = ST_LOSS_OF_SYNC;
    endcase

    if (!signal_detect) state_nxt = ST_LOSS_OF_SYNC;
    if (state_nxt == ST_LOSS_OF_SYNC) good_cnt_nxt = '0;

    // Entering a comma-detect state pins the comma to an even position.
    even_nxt = (state_nxt inside {ST_COMMA_DETECT_1, ST_COMMA_DETECT_2, ST_COMMA_DETECT_3})
               ? 1'b1 : !EVEN;
  end

  always_ff @(posedge clk or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      state    <= ST_LOSS_OF_SYNC;
      good_cnt <= '0;
      EVEN     <= 1'b0;
      SUDI_q   <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_cnt_nxt;
      EVEN     <= even_nxt;
      SUDI_q   <= SUDI;
    end
  end

  assign sync_status = is_sync_acquired(state);
  assign sync_state  = state;

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// Bench for rx_sync_ctrl: directed sync scenarios plus randomized code-group streams against a model.
module tb_rx_sync_ctrl;
  import rx_sync_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       mr_main_reset;
  logic [9:0] SUDI;
  logic       signal_detect;
  logic [9:0] SUDI_q;
  logic       EVEN;
  logic       sync_status;
  logic [3:0] sync_state;

  int checks = 0;
  int errors = 0;

  rx_sync_ctrl dut (
    .clk           (clk),
    .mr_main_reset (mr_main_reset),
    .SUDI          (SUDI),
    .signal_detect (signal_detect),
    .SUDI_q        (SUDI_q),
    .EVEN          (EVEN),
    .sync_status   (sync_status),
    .sync_state    (sync_state)
  );

  always #5 clk = ~clk;

  // RD- 6b forms for D.0..D.31 and RD- 4b forms for y=0..6, P7, A7.
  localparam logic [5:0] T6N [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [3:0] T4N [9] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110, 4'b0111};

  bit is_data [1024];

  // Standard 8b/10b encoder for D.x.y with starting running disparity rd (1 = RD+).
  function automatic logic [9:0] enc(input int x, input int y, input bit rd);
    logic [5:0] s;
    logic [3:0] f;
    bit         mid;
    int         yi;
    s = T6N[x];
    if (rd && !($countones(s) == 3 && x != 7)) s = ~s;
    mid = rd ^ ($countones(s) != 3);
    yi  = y;
    if (y == 7 && ((!mid && (x == 17 || x == 18 || x == 20)) ||
                   (mid && (x == 11 || x == 13 || x == 14)))) yi = 8;
    f = T4N[yi];
    if (mid && ($countones(f) != 2 || y == 3)) f = ~f;
    return {s, f};
  endfunction

  function automatic bit is_k(input logic [9:0] v);
    return v inside {10'h0FA, 10'h305, 10'h3A8, 10'h057, 10'h368, 10'h097, 10'h2E8, 10'h117};
  endfunction

  // Model: m_lvl 0 = not synced, 1..4 = sync level with a run of m_good good code-groups;
  // while not synced, m_commas commas have been accepted and m_cd means one was just seen.
  bit         m_even, m_cd;
  int         m_lvl, m_good, m_commas;
  logic [9:0] m_sudi_q;

  task automatic m_lose();
    m_lvl = 0; m_good = 0; m_commas = 0; m_cd = 0;
  endtask

  task automatic m_reset();
    m_lose();
    m_even   = 0;
    m_sudi_q = '0;
  endtask

  task automatic m_step(input logic [9:0] s, input logic sd);
    bit d_ok, k_ok, cm, bad;
    d_ok = is_data[s];
    k_ok = is_k(s);
    cm   = (s == 10'h0FA) || (s == 10'h305);
    bad  = !(d_ok || k_ok) || (cm && m_even);
    m_sudi_q = s;
    if (!sd) m_lose();
    else if (m_lvl > 0) begin
      if (bad) begin
        if (m_lvl == 4) m_lose();
        else begin m_lvl++; m_good = 0; end
      end else if (m_lvl > 1) begin
        if (m_good == 3) begin m_lvl--; m_good = 0; end
        else m_good++;
      end
    end else if (m_cd) begin
      m_cd = 0;
      if (!d_ok) m_lose();
      else if (m_commas == 3) begin m_lvl = 1; m_good = 0; end
    end else if (m_commas == 0) begin
      if (cm) begin m_commas = 1; m_cd = 1; end
    end else if (bad) m_lose();
    else if (cm && !m_even) begin m_commas++; m_cd = 1; end
    m_even = m_cd ? 1'b1 : !m_even;
  endtask

  function automatic logic [3:0] m_state();
    case (m_lvl)
      1: return ST_SYNC_ACQUIRED_1;
      2: return (m_good == 0) ? ST_SYNC_ACQUIRED_2 : ST_SYNC_ACQUIRED_2A;
      3: return (m_good == 0) ? ST_SYNC_ACQUIRED_3 : ST_SYNC_ACQUIRED_3A;
      4: return (m_good == 0) ? ST_SYNC_ACQUIRED_4 : ST_SYNC_ACQUIRED_4A;
      default: ;
    endcase
    if (m_cd) return (m_commas == 1) ? ST_COMMA_DETECT_1 :
                     (m_commas == 2) ? ST_COMMA_DETECT_2 : ST_COMMA_DETECT_3;
    if (m_commas == 0) return ST_LOSS_OF_SYNC;
    return (m_commas == 1) ? ST_ACQUIRE_SYNC_1 : ST_ACQUIRE_SYNC_2;
  endfunction

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One code-group per edge; outputs compared 1 time unit after the edge.
  task automatic cyc(input logic [9:0] s, input logic sd);
    SUDI = s;
    signal_detect = sd;
    @(posedge clk);
    m_step(s, sd);
    #1;
    chk("sudi_q", SUDI_q, m_sudi_q);
    chk("even", {9'd0, EVEN}, {9'd0, m_even});
    chk("sync_status", {9'd0, sync_status}, {9'd0, (m_lvl > 0)});
    chk("sync_state", {6'd0, sync_state}, {6'd0, m_state()});
  endtask

  task automatic acquire();
    cyc(10'h0FA, 1); cyc(10'h1B5, 1); cyc(10'h305, 1);
    cyc(10'h245, 1); cyc(10'h0FA, 1); cyc(10'h1B5, 1);
  endtask

  logic [9:0] acq_seq [6] = '{10'h0FA, 10'h1B5, 10'h305, 10'h245, 10'h0FA, 10'h1B5};
  logic       acq_even [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [3:0] loss_st [4] = '{ST_SYNC_ACQUIRED_2, ST_SYNC_ACQUIRED_3,
                              ST_SYNC_ACQUIRED_4, ST_LOSS_OF_SYNC};
  logic       loss_ss [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    logic [9:0] v;
    logic       sd;
    int         r;
    bit         ph;

    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 8; y++)
        for (int rd = 0; rd < 2; rd++) is_data[enc(x, y, rd[0])] = 1'b1;

    mr_main_reset = 1'b1;
    SUDI = '0;
    signal_detect = 1'b1;
    m_reset();
    #2;
    chk("reset_sudi_q", SUDI_q, 10'h000);
    chk("reset_even", {9'd0, EVEN}, 10'd0);
    chk("reset_sync_status", {9'd0, sync_status}, 10'd0);
    chk("reset_state", {6'd0, sync_state}, {6'd0, ST_LOSS_OF_SYNC});
    @(negedge clk);
    mr_main_reset = 1'b0;

    // Comma/data pairs acquire sync on the sixth code-group.
    for (int i = 0; i < 6; i++) begin
      cyc(acq_seq[i], 1);
      chk("acq_even", {9'd0, EVEN}, {9'd0, acq_even[i]});
    end
    chk("acq_sync_status", {9'd0, sync_status}, 10'd1);
    chk("acq_state", {6'd0, sync_state}, {6'd0, ST_SYNC_ACQUIRED_1});

    // Comma in an odd slot.
    cyc(10'h1B5, 1);
    chk("odd_pre_even", {9'd0, EVEN}, 10'd1);
    cyc(10'h0FA, 1);
    chk("odd_comma_state", {6'd0, sync_state}, {6'd0, ST_SYNC_ACQUIRED_2});
    chk("odd_comma_sync", {9'd0, sync_status}, 10'd1);

    // Four goods promote back to SYNC_ACQUIRED_1.
    for (int i = 1; i <= 4; i++) begin
      cyc(10'h2AA, 1);
      chk("rec_state", {6'd0, sync_state},
          {6'd0, (i < 4) ? ST_SYNC_ACQUIRED_2A : ST_SYNC_ACQUIRED_1});
      chk("rec_good_cnt", {8'd0, dut.good_cnt}, (i < 4) ? 10'(i) : 10'd0);
    end
    cyc(10'h000, 1); cyc(10'h2AA, 1); cyc(10'h2AA, 1); cyc(10'h000, 1);
    chk("rec_bad3_state", {6'd0, sync_state}, {6'd0, ST_SYNC_ACQUIRED_3});
    chk("rec_bad3_good_cnt", {8'd0, dut.good_cnt}, 10'd0);
    for (int i = 0; i < 8; i++) cyc(10'h2AA, 1);
    chk("rec_back_state", {6'd0, sync_state}, {6'd0, ST_SYNC_ACQUIRED_1});

    // Four invalid code-groups lose sync.
    for (int i = 0; i < 4; i++) begin
      cyc(10'h000, 1);
      chk("loss_state", {6'd0, sync_state}, {6'd0, loss_st[i]});
      chk("loss_sync", {9'd0, sync_status}, {9'd0, loss_ss[i]});
    end

    // signal_detect drop overrides a valid code-group.
    acquire();
    cyc(10'h2AA, 0);
    chk("sigdet_state", {6'd0, sync_state}, {6'd0, ST_LOSS_OF_SYNC});
    chk("sigdet_sync", {9'd0, sync_status}, 10'd0);
    cyc(10'h2AA, 1);

    // Randomized stream: mostly comma/data pairs, with garbage bursts, K codes and signal drops.
    ph = 0;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(99);
      if ((n % 400) < 30) v = 10'($urandom_range(1023));
      else if (!ph) v = (r < 92) ? ((r % 2 == 0) ? 10'h0FA : 10'h305)
                                 : enc($urandom_range(31), $urandom_range(7), 1'($urandom_range(1)));
      else if (r < 93) v = enc($urandom_range(31), $urandom_range(7), 1'($urandom_range(1)));
      else if (r < 97) v = (r % 2 == 0) ? 10'h3A8 : 10'h117;
      else v = 10'($urandom_range(1023));
      sd = ($urandom_range(299) != 0);
      if (r == 50) ph = !ph;
      ph = !ph;
      cyc(v, sd);
    end

    // Asynchronous reset in the middle of sync, between edges.
    acquire();
    #2;
    mr_main_reset = 1'b1;
    #1;
    m_reset();
    chk("mid_reset_sync", {9'd0, sync_status}, 10'd0);
    chk("mid_reset_even", {9'd0, EVEN}, 10'd0);
    chk("mid_reset_state", {6'd0, sync_state}, {6'd0, ST_LOSS_OF_SYNC});
    chk("mid_reset_sudi_q", SUDI_q, 10'h000);
    @(negedge clk);
    mr_main_reset = 1'b0;
    cyc(10'h305, 1);
    chk("post_reset_state", {6'd0, sync_state}, {6'd0, ST_COMMA_DETECT_1});
    chk("post_reset_even", {9'd0, EVEN}, 10'd1);
    cyc(10'h245, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_sync_ctrl.md
RX_SYNC_CTRL -- requirements
Module: rx_sync_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: receive clock; all state changes on its rising edge.
REQ-003 Port mr_main_reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port SUDI, input, 10 bits: raw received code-group, one per clk.
REQ-005 Port signal_detect, input, 1 bit: PMD signal present.
REQ-006 Port SUDI_q, output, 10 bits: SUDI registered one cycle, aligned with EVEN and sync_status.
REQ-007 Port EVEN, output, 1 bit: 1 when SUDI_q sits at an even code-group position.
REQ-008 Port sync_status, output, 1 bit: 1 = OK, 0 = FAIL; gates the RECEIVE block.
REQ-009 Port sync_state, output, 4 bits: current state encoding, for debug.

Function
REQ-010 Classification, combinational on SUDI: comma = K28.5 (either disparity); data = any D code-group in the shared code-group list; valid = data, or any K code-group in that list; cgbad = !valid, or comma while EVEN==1; cggood = !cgbad.
REQ-011 FSM states: LOSS_OF_SYNC, COMMA_DETECT_1/2/3, ACQUIRE_SYNC_1/2, SYNC_ACQUIRED_1, SYNC_ACQUIRED_2/2A, SYNC_ACQUIRED_3/3A, SYNC_ACQUIRED_4/4A.
REQ-012 FSM updates registered, once per clk; each update samples SUDI, and SUDI_q <= SUDI on the same edge.
REQ-013 LOSS_OF_SYNC: EVEN <= !EVEN; on comma, go to COMMA_DETECT_1; otherwise stay.
REQ-014 COMMA_DETECT_n (n=1..3): EVEN <= 1; on data, go to ACQUIRE_SYNC_n (SYNC_ACQUIRED_1 when n=3); otherwise go to LOSS_OF_SYNC.
REQ-015 ACQUIRE_SYNC_n (n=1,2): EVEN <= !EVEN; cgbad goes to LOSS_OF_SYNC; comma with EVEN==0 goes to COMMA_DETECT_(n+1); otherwise stay.
REQ-016 SYNC_ACQUIRED_1: EVEN <= !EVEN; cgbad goes to SYNC_ACQUIRED_2 with good_cnt <= 0; cggood stays.
REQ-017 SYNC_ACQUIRED_k and SYNC_ACQUIRED_kA (k=2..4): EVEN <= !EVEN.
  - cggood: good_cnt <= good_cnt+1 and go to kA; when good_cnt==3, go to SYNC_ACQUIRED_(k-1) with good_cnt <= 0.
  - cgbad: go to SYNC_ACQUIRED_(k+1) with good_cnt <= 0; when k==4, go to LOSS_OF_SYNC.
REQ-018 good_cnt SHALL be 2 bits, saturating at 3; it is never wrapped, since the 4th consecutive good promotes the state.
REQ-019 sync_status SHALL be 1 exactly when the registered state is any SYNC_ACQUIRED_* state.
REQ-020 signal_detect==0 at any edge SHALL force LOSS_OF_SYNC, overriding all other transitions; EVEN toggles per REQ-013.
REQ-021 Latency: SUDI to SUDI_q/EVEN/sync_status SHALL be exactly 1 cycle.

Reset
REQ-022 Asserting mr_main_reset SHALL immediately force state LOSS_OF_SYNC, EVEN=0, sync_status=0, SUDI_q=0, good_cnt=0, sync_state=LOSS_OF_SYNC encoding, independent of clk.
REQ-023 Reset asserted mid-sync SHALL drop sync_status asynchronously.
REQ-024 After reset release, the first active edge SHALL evaluate LOSS_OF_SYNC.

Structure
REQ-025 State encodings (4-bit) and comma/data/valid code-group constants SHALL live in the shared code-group include file, not locally.
REQ-026 One combinational sub-module, cg_classify (SUDI, EVEN -> comma, data, cgbad), SHALL be instantiated; the FSM and registers stay in rx_sync_ctrl.

Verification
REQ-027 Reset check: assert mr_main_reset between edges -> sync_status=0, EVEN=0, sync_state=LOSS_OF_SYNC before the next clk edge.
REQ-028 Acquisition: after reset, drive K28.5, D16.2, K28.5, D16.2, K28.5, D16.2 -> EVEN=1,0,1,0,1,0 and sync_status=1 on the 6th edge.
REQ-029 Odd comma: in SYNC_ACQUIRED_1 with EVEN==1, drive K28.5 -> SYNC_ACQUIRED_2, sync_status stays 1.
REQ-030 Loss: from SYNC_ACQUIRED_1, drive 10'h000 four times -> SYNC_ACQUIRED_2, 3, 4, then LOSS_OF_SYNC, with sync_status=0 on the 4th edge.
REQ-031 Recovery: in SYNC_ACQUIRED_2, drive 4 good code-groups -> SYNC_ACQUIRED_2A (good_cnt 1,2,3), then SYNC_ACQUIRED_1 on the 4th; with a bad on the 3rd instead -> SYNC_ACQUIRED_3, good_cnt=0.
REQ-032 signal_detect: deassert for one cycle while in SYNC_ACQUIRED_1 -> LOSS_OF_SYNC and sync_status=0 at that edge, even with valid SUDI.
